inst_dec_pipe: RTL and testbench
================================

# inst_dec_pipe

Parametrised, pipelined successor of the core instruction decoder. Accepts instruction words over a valid/ready handshake, decodes them into ALU opcode, register selects, immediate, write-enable and illegal-opcode flag, and presents the results registered to the execute stage over a second valid/ready handshake. A 2-entry skid buffer decouples back-pressure, and flush support is provided for branch redirects. Sits between fetch and the register file/ALU.

## Interface
- INST_W, 16: instruction width; must be ≥ 5 + 3*RSEL_W and ≥ 8.
- RSEL_W, 3: register-select width (2^RSEL_W registers).
- DATA_W, 16: immediate output width, ≥ 8.
- NOWB_MASK, 16'h3800: bit[op]=1 means opcode op does not write back (O_Regwe=0).
- ILL_MASK, 16'h0000: bit[op]=1 means opcode op is illegal.
- CNT_W, 16: width of the decoded-instruction counter.

Ports:
- I_Clk  in  1  clock, rising edge.
- I_Rst  in  1  asynchronous, active-high reset.
- I_En  in  1  global enable; when 0, no transfers occur and all state holds.
- I_Flush  in  1  discard all buffered/output instructions.
- I_Valid  in  1  instruction valid from fetch.
- O_Ready  out  1  decoder can accept.
- I_Inst  in  INST_W  instruction word.
- O_Valid  out  1  decoded result valid.
- I_Ready  in  1  execute stage accepts.
- O_Aluop  out  5  {opcode, flag}.
- O_SelD, O_SelA, O_SelB  out  RSEL_W each  destination/source selects.
- O_Imm  out  DATA_W  immediate.
- O_Regwe  out  1  register write enable.
- O_Illegal  out  1  opcode flagged by ILL_MASK.
- O_Count  out  CNT_W  number of results accepted by execute.

## Operation
- Field extraction (MSB first): opcode = I_Inst[INST_W-1 -: 4]; rD = next RSEL_W bits; flag = next bit; rA = next RSEL_W; rB = next RSEL_W; imm8 = I_Inst[7:0].
- O_Aluop = {opcode, flag}; O_SelD/A/B = rD/rA/rB.
- O_Imm: flag=1 → imm8 in bits [DATA_W-1 -: 8], rest 0; flag=0 → imm8 zero-extended.
- O_Regwe = ~NOWB_MASK[opcode]; O_Illegal = ILL_MASK[opcode]. An illegal instruction still flows; O_Regwe is forced 0 when O_Illegal=1.
- Input transfer: I_En & I_Valid & O_Ready. Output transfer: I_En & O_Valid & I_Ready.
- Storage: output register (OUT) plus one skid entry (SKID). States: EMPTY (OUT invalid), ONE (OUT valid, SKID empty), FULL (both valid).
  - EMPTY: input transfer → decode into OUT → ONE.
  - ONE: in only → if output transfer also occurs, reload OUT, stay ONE; otherwise capture into SKID → FULL. Out only → EMPTY.
  - FULL: O_Ready=0; output transfer → SKID moves to OUT → ONE.
- O_Ready = I_En & (state != FULL), derived from registered state only (no combinational path from I_Ready).
- I_Flush (qualified by I_En) has priority over everything: state → EMPTY next cycle; a same-cycle input transfer is dropped; O_Count still increments if an output transfer occurs that cycle.
- O_Count increments by 1 per output transfer, wraps modulo 2^CNT_W.

## Timing
- Reset (async assert, sync release): state EMPTY, O_Valid=0, O_Ready=0 while I_Rst high, then 1 from the first cycle after release when I_En=1; O_Aluop, selects, O_Imm, O_Regwe, O_Illegal, O_Count all 0.
- Latency: 1 cycle, input transfer at edge N → O_Valid with decoded fields after edge N.
- Throughput: 1 instruction/cycle when I_Ready is held high.
- Output fields are stable while O_Valid=1 and I_Ready=0.
- Reset mid-operation: buffered instructions are discarded and the count is cleared immediately.

## Structure
- Shared package inst_dec_pkg: opcode field width (4), ALUOP width (5), imm8 width (8), opcode localparams, and the decoded-bundle struct/concatenation layout.
- Sub-module dec_fields: purely combinational field extraction/immediate/regwe/illegal logic. It is instantiated once on I_Inst, so OUT and SKID hold decoded bundles.
- Top level holds the FSM, skid buffer and counter.

## Test plan
- Reset/basic: after reset, I_Inst=16'b0001_011_1_000_001_00 (hex 0x1704) with I_En=1, valid, I_Ready=1 → next cycle O_Aluop=5'b00011, O_SelD=3, O_SelA=0, O_SelB=1, O_Imm=16'h0400, O_Regwe=1, O_Count=1.
- Immediate/no-writeback: opcode 4'b1011, flag=0, imm8=0x04 → O_Imm=16'h0004, O_Regwe=0; opcode 4'b1100 → O_Regwe=0.
- Back-pressure: stream 3 instructions with I_Ready=0 → O_Ready low after 2 accepted. Release I_Ready → results emerge in order; the third is accepted only after the first drains.
- Flush: FULL state, assert I_Flush with I_Valid=1 → next cycle O_Valid=0 and the input is dropped; O_Count unchanged.
- Enable/illegal: I_En=0 for 3 cycles → no transfers, outputs held. ILL_MASK=16'h8000, opcode 4'b1111 → O_Illegal=1, O_Regwe=0.
- Counter wrap with CNT_W=4: 17 transfers → O_Count=1.

Source files
------------

// File: rtl/inst_dec_pkg.sv
// Shared types for the pipelined instruction decoder.
// Opcodes, FSM states and the decoded-bundle layout.
package inst_dec_pkg;

    localparam int OPC_W   = 4;
    localparam int ALUOP_W = 5;
    localparam int IMM8_W  = 8;

    typedef enum logic [OPC_W-1:0] {
        OP_ADD   = 4'h0,
        OP_SUB   = 4'h1,
        OP_AND   = 4'h2,
        OP_OR    = 4'h3,
        OP_XOR   = 4'h4,
        OP_NOT   = 4'h5,
        OP_READ  = 4'h6,
        OP_WRITE = 4'h7,
        OP_LOAD  = 4'h8,
        OP_CMP   = 4'h9,
        OP_SHL   = 4'hA,
        OP_JUMP  = 4'hB,
        OP_JMPC  = 4'hC,
        OP_STORE = 4'hD,
        OP_SHR   = 4'hE,
        OP_SPEC  = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    typedef struct packed {
        logic regwe;
        logic illegal;
    } dec_flags_t;

    // Bundle layout, MSB first:
    // {aluop, selD, selA, selB, imm, regwe, illegal}
    function automatic int dec_w(input int rsel_w, input int data_w);
        return ALUOP_W + 3 * rsel_w + data_w + 2;
    endfunction

endpackage

// File: rtl/inst_dec_pipe_if.sv
// Fetch-side and execute-side handshakes of the decoder.
// master drives instructions/ready, slave is the decoder.
interface inst_dec_pipe_if
    import inst_dec_pkg::*;
#(
    parameter int INST_W = 16,
    parameter int RSEL_W = 3,
    parameter int DATA_W = 16
);
    logic                I_Valid;
    logic                O_Ready;
    logic [INST_W-1:0]   I_Inst;
    logic                O_Valid;
    logic                I_Ready;
    logic [ALUOP_W-1:0]  O_Aluop;
    logic [RSEL_W-1:0]   O_SelD;
    logic [RSEL_W-1:0]   O_SelA;
    logic [RSEL_W-1:0]   O_SelB;
    logic [DATA_W-1:0]   O_Imm;
    logic                O_Regwe;
    logic                O_Illegal;

    modport master (
        output I_Valid, I_Inst, I_Ready,
        input  O_Ready, O_Valid, O_Aluop, O_SelD, O_SelA,
        input  O_SelB, O_Imm, O_Regwe, O_Illegal
    );

    modport slave (
        input  I_Valid, I_Inst, I_Ready,
        output O_Ready, O_Valid, O_Aluop, O_SelD, O_SelA,
        output O_SelB, O_Imm, O_Regwe, O_Illegal
    );
endinterface

// File: rtl/inst_dec_pipe_dec_fields.sv
// Combinational field extraction for one instruction word.
// Produces the packed decoded bundle stored by the pipe.
module dec_fields
    import inst_dec_pkg::*;
#(
    parameter int          INST_W    = 16,
    parameter int          RSEL_W    = 3,
    parameter int          DATA_W    = 16,
    parameter logic [15:0] NOWB_MASK = 16'h3800,
    parameter logic [15:0] ILL_MASK  = 16'h0000
) (
    input  logic [INST_W-1:0]                  i_inst,
    output logic [dec_w(RSEL_W, DATA_W)-1:0]   o_dec
);
    localparam int P_OPC  = INST_W - 1;
    localparam int P_RD   = P_OPC - OPC_W;
    localparam int P_FLAG = P_RD - RSEL_W;
    localparam int P_RA   = P_FLAG - 1;
    localparam int P_RB   = P_RA - RSEL_W;

    opcode_e             w_opc;
    logic [RSEL_W-1:0]   w_rd;
    logic [RSEL_W-1:0]   w_ra;
    logic [RSEL_W-1:0]   w_rb;
    logic                w_flag;
    logic [IMM8_W-1:0]   w_imm8;
    logic [DATA_W-1:0]   w_imm_z;
    logic [DATA_W-1:0]   w_imm;
    dec_flags_t          w_flags;

    assign w_opc   = opcode_e'(i_inst[P_OPC -: OPC_W]);
    assign w_rd    = i_inst[P_RD -: RSEL_W];
    assign w_flag  = i_inst[P_FLAG];
    assign w_ra    = i_inst[P_RA -: RSEL_W];
    assign w_rb    = i_inst[P_RB -: RSEL_W];
    assign w_imm8  = i_inst[IMM8_W-1:0];

    // flag selects a high-placed immediate instead of zero-extension
    assign w_imm_z = DATA_W'(w_imm8);
    assign w_imm   = w_flag ? (w_imm_z << (DATA_W - IMM8_W)) : w_imm_z;

    // illegal opcodes still flow but never write back
    assign w_flags.illegal = ILL_MASK[w_opc];
    assign w_flags.regwe   = ~NOWB_MASK[w_opc] & ~ILL_MASK[w_opc];

    assign o_dec = {w_opc, w_flag, w_rd, w_ra, w_rb, w_imm, w_flags};

endmodule

// File: rtl/inst_dec_pipe.sv
// Pipelined instruction decoder with a 2-entry skid buffer.
// Holds the OUT/SKID FSM, flush handling and result counter.
module inst_dec_pipe
    import inst_dec_pkg::*;
#(
    parameter int          INST_W    = 16,
    parameter int          RSEL_W    = 3,
    parameter int          DATA_W    = 16,
    parameter logic [15:0] NOWB_MASK = 16'h3800,
    parameter logic [15:0] ILL_MASK  = 16'h0000,
    parameter int          CNT_W     = 16
) (
    input  logic              I_Clk,
    input  logic              I_Rst,
    input  logic              I_En,
    input  logic              I_Flush,
    inst_dec_pipe_if.slave    bus,
    output logic [CNT_W-1:0]  O_Count
);
    localparam int DEC_W = dec_w(RSEL_W, DATA_W);

    logic [DEC_W-1:0] w_dec;
    logic [DEC_W-1:0] r_out;
    logic [DEC_W-1:0] r_skid;
    logic [CNT_W-1:0] r_cnt;
    state_e           r_state;
    state_e           w_state_nxt;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic             w_ld_out;
    logic             w_ld_skid;
    logic             w_from_skid;

    dec_fields #(
        .INST_W    (INST_W),
        .RSEL_W    (RSEL_W),
        .DATA_W    (DATA_W),
        .NOWB_MASK (NOWB_MASK),
        .ILL_MASK  (ILL_MASK)
    ) u_dec (
        .i_inst (bus.I_Inst),
        .o_dec  (w_dec)
    );

    assign bus.O_Ready = I_En & ~I_Rst & (r_state != ST_FULL);
    assign bus.O_Valid = (r_state != ST_EMPTY);
    assign w_in_xfer   = I_En & bus.I_Valid & bus.O_Ready;
    assign w_out_xfer  = I_En & bus.O_Valid & bus.I_Ready;

    assign {bus.O_Aluop, bus.O_SelD, bus.O_SelA, bus.O_SelB,
            bus.O_Imm, bus.O_Regwe, bus.O_Illegal} = r_out;
    assign O_Count = r_cnt;

    // state register
    always_ff @(posedge I_Clk or posedge I_Rst) begin
        if (I_Rst) r_state <= ST_EMPTY;
        else       r_state <= w_state_nxt;
    end

    // next state and buffer load controls; flush wins
    always_comb begin
        w_state_nxt = r_state;
        w_ld_out    = 1'b0;
        w_ld_skid   = 1'b0;
        w_from_skid = 1'b0;
        if (I_En && I_Flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            unique case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        w_ld_out    = 1'b1;
                        w_state_nxt = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_in_xfer && w_out_xfer) begin
                        w_ld_out = 1'b1;
                    end else if (w_in_xfer) begin
                        w_ld_skid   = 1'b1;
                        w_state_nxt = ST_FULL;
                    end else if (w_out_xfer) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_out_xfer) begin
                        w_ld_out    = 1'b1;
                        w_from_skid = 1'b1;
                        w_state_nxt = ST_ONE;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    // OUT and SKID decoded-bundle storage
    always_ff @(posedge I_Clk or posedge I_Rst) begin
        if (I_Rst) begin
            r_out  <= '0;
            r_skid <= '0;
        end else begin
            if (w_ld_out)  r_out  <= w_from_skid ? r_skid : w_dec;
            if (w_ld_skid) r_skid <= w_dec;
        end
    end

    // results accepted by execute, counted even on a flush cycle
    always_ff @(posedge I_Clk or posedge I_Rst) begin
        if (I_Rst)           r_cnt <= '0;
        else if (w_out_xfer) r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: tb/tb_inst_dec_pipe.sv
// Self-checking bench for inst_dec_pipe.
// Queue-based reference model plus directed literal checks.
module tb_inst_dec_pipe;

    localparam logic [15:0] NOWB = 16'h3800;
    localparam logic [15:0] ILL  = 16'h8000;

    typedef struct {
        logic [4:0]  aluop;
        logic [2:0]  d;
        logic [2:0]  a;
        logic [2:0]  b;
        logic [15:0] imm;
        logic        we;
        logic        ill;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic       flush;
    logic [3:0] count;

    int n_checks = 0;
    int n_err    = 0;

    exp_t       q[$];
    logic [3:0] mcnt;

    inst_dec_pipe_if #(.INST_W(16), .RSEL_W(3), .DATA_W(16)) u_if ();

    inst_dec_pipe #(
        .INST_W    (16),
        .RSEL_W    (3),
        .DATA_W    (16),
        .NOWB_MASK (NOWB),
        .ILL_MASK  (ILL),
        .CNT_W     (4)
    ) dut (
        .I_Clk   (clk),
        .I_Rst   (rst),
        .I_En    (en),
        .I_Flush (flush),
        .bus     (u_if),
        .O_Count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t decode(input logic [15:0] x);
        exp_t e;
        int   op;
        op      = int'(x >> 12);
        e.aluop = 5'((op << 1) | int'(x[8]));
        e.d     = 3'((x >> 9) & 16'h7);
        e.a     = 3'((x >> 5) & 16'h7);
        e.b     = 3'((x >> 2) & 16'h7);
        e.imm   = x[8] ? ((x & 16'h00FF) << 8) : (x & 16'h00FF);
        e.ill   = ((ILL >> op) & 16'h1) != 0;
        e.we    = (((NOWB >> op) & 16'h1) == 0) && !e.ill;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // reference model: an in-order queue of at most two results
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            mcnt = 4'd0;
        end else begin
            logic m_in, m_out;
            m_in  = en && u_if.I_Valid && (q.size() < 2);
            m_out = en && (q.size() > 0) && u_if.I_Ready;
            if (m_out) mcnt = mcnt + 4'd1;
            if (en && flush) begin
                q.delete();
            end else begin
                if (m_out) void'(q.pop_front());
                if (m_in)  q.push_back(decode(u_if.I_Inst));
            end
        end
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin
        chk("ready", 32'(u_if.O_Ready),
            32'(en && !rst && (q.size() < 2)));
        chk("valid", 32'(u_if.O_Valid), 32'(q.size() > 0));
        chk("count", 32'(count), 32'(mcnt));
        if (q.size() > 0) begin
            chk("aluop", 32'(u_if.O_Aluop),   32'(q[0].aluop));
            chk("seld",  32'(u_if.O_SelD),    32'(q[0].d));
            chk("sela",  32'(u_if.O_SelA),    32'(q[0].a));
            chk("selb",  32'(u_if.O_SelB),    32'(q[0].b));
            chk("imm",   32'(u_if.O_Imm),     32'(q[0].imm));
            chk("regwe", 32'(u_if.O_Regwe),   32'(q[0].we));
            chk("ill",   32'(u_if.O_Illegal), 32'(q[0].ill));
        end
    end

    task automatic step(input logic v, input logic [15:0] inst,
                        input logic r);
        u_if.I_Valid = v;
        u_if.I_Inst  = inst;
        u_if.I_Ready = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        en           = 1'b1;
        flush        = 1'b0;
        u_if.I_Valid = 1'b0;
        u_if.I_Inst  = 16'h0;
        u_if.I_Ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(u_if.O_Ready), 32'd0);
        chk("rst_valid", 32'(u_if.O_Valid), 32'd0);
        chk("rst_count", 32'(count),        32'd0);
        chk("rst_aluop", 32'(u_if.O_Aluop), 32'd0);
        chk("rst_imm",   32'(u_if.O_Imm),   32'd0);
        chk("rst_regwe", 32'(u_if.O_Regwe), 32'd0);
        rst = 1'b0;
        step(1'b0, 16'h0, 1'b1);
        chk("ready_after_rst", 32'(u_if.O_Ready), 32'd1);

        // basic decode with flag=1 immediate
        step(1'b1, 16'h1704, 1'b1);
        chk("b_valid", 32'(u_if.O_Valid), 32'd1);
        chk("b_aluop", 32'(u_if.O_Aluop), 32'b00011);
        chk("b_seld",  32'(u_if.O_SelD),  32'd3);
        chk("b_sela",  32'(u_if.O_SelA),  32'd0);
        chk("b_selb",  32'(u_if.O_SelB),  32'd1);
        chk("b_imm",   32'(u_if.O_Imm),   32'h0400);
        chk("b_regwe", 32'(u_if.O_Regwe), 32'd1);
        step(1'b0, 16'h0, 1'b1);
        chk("b_count", 32'(count), 32'd1);

        // zero-extended immediate and no-writeback opcodes
        step(1'b1, 16'hB004, 1'b1);
        chk("nw_imm",   32'(u_if.O_Imm),   32'h0004);
        chk("nw_regwe", 32'(u_if.O_Regwe), 32'd0);
        step(1'b1, 16'hC004, 1'b1);
        chk("c_regwe", 32'(u_if.O_Regwe), 32'd0);
        chk("c_count", 32'(count),        32'd2);
        step(1'b0, 16'h0, 1'b1);
        chk("c_count2", 32'(count), 32'd3);

        // back-pressure: two accepted, third waits
        step(1'b1, 16'h2204, 1'b0);
        step(1'b1, 16'h2404, 1'b0);
        chk("bp_ready_low", 32'(u_if.O_Ready), 32'd0);
        step(1'b1, 16'h2604, 1'b0);
        chk("bp_hold_seld", 32'(u_if.O_SelD), 32'd1);
        step(1'b1, 16'h2604, 1'b1);
        chk("bp_second", 32'(u_if.O_SelD), 32'd2);
        step(1'b1, 16'h2604, 1'b1);
        chk("bp_third", 32'(u_if.O_SelD), 32'd3);
        step(1'b0, 16'h0, 1'b1);
        chk("bp_count", 32'(count), 32'd6);

        // flush from FULL drops the concurrent input
        step(1'b1, 16'h4204, 1'b0);
        step(1'b1, 16'h4404, 1'b0);
        flush = 1'b1;
        step(1'b1, 16'h4604, 1'b0);
        flush = 1'b0;
        chk("fl_valid", 32'(u_if.O_Valid), 32'd0);
        chk("fl_count", 32'(count),        32'd6);
        step(1'b0, 16'h0, 1'b1);
        chk("fl_dropped", 32'(u_if.O_Valid), 32'd0);

        // global enable low freezes everything
        step(1'b1, 16'h3A08, 1'b0);
        en = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 16'h5E04, 1'b1);
        chk("en_ready", 32'(u_if.O_Ready), 32'd0);
        chk("en_valid", 32'(u_if.O_Valid), 32'd1);
        chk("en_seld",  32'(u_if.O_SelD),  32'd5);
        chk("en_imm",   32'(u_if.O_Imm),   32'h0008);
        chk("en_count", 32'(count),        32'd6);
        en = 1'b1;
        step(1'b0, 16'h0, 1'b1);
        chk("en_count2", 32'(count), 32'd7);

        // illegal opcode flows with write-enable suppressed
        step(1'b1, 16'hF004, 1'b1);
        chk("il_flag",  32'(u_if.O_Illegal), 32'd1);
        chk("il_regwe", 32'(u_if.O_Regwe),   32'd0);
        chk("il_aluop", 32'(u_if.O_Aluop),   32'b11110);
        step(1'b0, 16'h0, 1'b1);
        chk("il_count", 32'(count), 32'd8);

        // counter wraps at 16 after 17 total transfers
        for (int i = 0; i < 9; i++) step(1'b1, 16'(i * 16'h1111), 1'b1);
        step(1'b0, 16'h0, 1'b1);
        chk("wrap_count", 32'(count), 32'd1);
        step(1'b0, 16'h0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
